tetris_field_engine: RTL and testbench
======================================

Name: tetris_field_engine

Overview:
- Parametrised playfield store with a command interface: collision check, block merge with multi-line compaction, and clear.
- Replaces the fixed-size, flattened field-plus-shift logic in the game FSM; the game FSM becomes a client issuing commands.
- Supports arbitrary ROWS/COLS/COLOR_W.
- Clears any number of full rows, adjacent or not, in one merge operation.
- Reports a top-out condition.

Parameters:
- ROWS, 20, playable rows; row 0 is the top.
- COLS, 10, playable columns; column 0 is the left.
- COLOR_W, 3, color code width; 0 means an empty cell.
- XW, $clog2(COLS)+2, signed block X width.
- YW, $clog2(ROWS)+2, signed block Y width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  engine idle; a command is accepted when valid&&ready at a rising edge
- cmd_op  in  2  0=CLEAR, 1=CHECK, 2=MERGE, 3=reserved (treated as CHECK)
- blk_mask  in  16  pre-rotated 4x4 shape; bit 4*i+j = block row i, column j
- blk_color  in  COLOR_W  color written by MERGE
- blk_x  in  XW signed  field column of block column 0
- blk_y  in  YW signed  field row of block row 0
- resp_valid  out  1  one-cycle response strobe; no backpressure
- resp_fit  out  1  CHECK: block fits; CLEAR/MERGE: 1
- resp_lines  out  3  MERGE: number of rows cleared (0..4); otherwise 0
- resp_top_hit  out  1  MERGE: a set cell had y<0; otherwise 0
- rd_row  in  $clog2(ROWS)  display read address
- rd_data  out  COLS*COLOR_W  combinational read of row rd_row; column c at bits [c*COLOR_W +: COLOR_W]
- field_stable  out  1  high unless in MERGE/COMPACT/FILL (display may latch)

Behaviour:
- Reset: all cells 0, state IDLE, cmd_ready=1, resp_* = 0, field_stable=1.
  - rst mid-operation aborts the operation and clears the field.
- Storage: ROWS registers of COLS*COLOR_W bits. Cell occupied iff its color != 0.
- Command inputs blk_mask/blk_color/blk_x/blk_y are registered on acceptance; changes afterwards are ignored.
- cmd_ready = (state==IDLE). cmd_valid while busy is ignored.
- States and transitions:
  - IDLE: on accept go to CLR, CHK0 or MRG per cmd_op.
  - CLR: zero all rows in one cycle -> RESP.
  - CHK0..CHK3: one block row i per cycle, cell (blk_y+i, blk_x+j) for each mask bit set:
    - collision if x<0, x>=COLS or y>=ROWS;
    - collision if 0<=y<ROWS and the cell is occupied;
    - y<0 is never a collision.
    - Sticky collide flag; CHK3 -> RESP.
  - MRG: write blk_color into every in-range masked cell in one cycle.
    - Cells with y<0 are discarded and set top_hit.
    - Out-of-range x or y>=ROWS cells are silently dropped (client must CHECK first).
    - Init rd_ptr=wr_ptr=ROWS-1, lines=0 -> COMPACT.
  - COMPACT: one row per cycle at rd_ptr.
    - If full (all COLS occupied): lines++.
    - Else: row[wr_ptr] <= row[rd_ptr], wr_ptr--.
    - rd_ptr--. When rd_ptr passes row 0 -> FILL, or RESP if lines==0.
  - FILL: zero row[wr_ptr], wr_ptr-- each cycle, `lines` cycles total -> RESP.
  - RESP: resp_valid=1 with fit/lines/top_hit for one cycle -> IDLE.
- Latency, counting from the accepting edge to the edge at which resp_valid is high:
  - CLEAR: 2 cycles.
  - CHECK: 5 cycles.
  - MERGE: 2+ROWS+lines cycles.
  - cmd_ready returns high the cycle after resp_valid. Back-to-back commands are accepted on that cycle.
- Arithmetic:
  - Coordinates are sign-extended to max(XW,YW)+1 before adding i/j; no wrap-around.
  - resp_lines saturates naturally at 4 (at most 4 block rows).
- rd_data during MERGE/COMPACT/FILL reflects intermediate contents; field_stable=0 flags this.

Decomposition:
- Package tetris_field_pkg:
  - op encodings (OP_CLEAR/OP_CHECK/OP_MERGE);
  - state enum;
  - helper function cell_in_field(x,y).
- One sub-module: tetris_row_full (combinational COLS-wide OR-reduce-per-cell then AND). Used on row[rd_ptr] in COMPACT.

Test Plan:
- Reset then read all rows -> rd_data=0 everywhere; cmd_ready=1; resp_valid=0.
- Empty field, CHECK O-piece mask 0x0033 at x=4,y=0 -> resp_valid 5 cycles after accept, fit=1. Same at x=-1 -> fit=0. At y=-1 -> fit=1.
- Fill row 19 columns 0..5 and 8..9, then MERGE mask 0x0033 color 5 at x=6,y=18 -> resp at accept+2+20+1=23 cycles:
  - lines=1;
  - row 19 = former row 18 with columns 6,7=5;
  - row 0 = 0.
- Prefill rows 16..19 full except column 0 and row 17 col 3 = 2; MERGE I-piece vertical (mask 0x1111) color 1 at x=0,y=16 -> lines=4, rows 0..3 zero, compacted rows shifted down 4, total latency 26.
- MERGE mask 0x0033 at y=-1 on empty field -> top_hit=1, only row 0 cols x,x+1 written, lines=0.
- Assert rst during COMPACT -> field all zero, cmd_ready=1, no resp_valid. CLEAR on full field -> latency 2, all rows 0.

Source files
------------

// File: rtl/tetris_field_pkg.sv
// Shared encodings and helpers for the playfield engine.
package tetris_field_pkg;

  localparam logic [1:0] OP_CLEAR = 2'd0;
  localparam logic [1:0] OP_CHECK = 2'd1;
  localparam logic [1:0] OP_MERGE = 2'd2;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_CLR     = 3'd1;
  localparam state_t ST_CHK     = 3'd2;
  localparam state_t ST_MRG     = 3'd3;
  localparam state_t ST_COMPACT = 3'd4;
  localparam state_t ST_FILL    = 3'd5;
  localparam state_t ST_RESP    = 3'd6;

  function automatic logic cell_in_field(input int x, input int y, input int rows, input int cols);
    return (x >= 0) && (x < cols) && (y >= 0) && (y < rows);
  endfunction

endpackage

// File: rtl/tetris_row_full.sv
// Flags a row whose every cell holds a non-zero color.
module tetris_row_full #(
  parameter int COLS    = 10,
  parameter int COLOR_W = 3
) (
  input  logic [COLS*COLOR_W-1:0] row_i,
  output logic                    full_o
);

  always_comb begin
    full_o = 1'b1;
    for (int unsigned c = 0; c < COLS; c++) begin
      if (row_i[c*COLOR_W +: COLOR_W] == '0) full_o = 1'b0;
    end
  end

endmodule

// File: rtl/tetris_field_engine.sv
// Playfield store serving CLEAR / CHECK / MERGE commands, with bottom-up
// line compaction after every merge.
module tetris_field_engine
  import tetris_field_pkg::*;
#(
  parameter int ROWS    = 20,
  parameter int COLS    = 10,
  parameter int COLOR_W = 3,
  parameter int XW      = $clog2(COLS) + 2,
  parameter int YW      = $clog2(ROWS) + 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [1:0]                  cmd_op,
  input  logic [15:0]                 blk_mask,
  input  logic [COLOR_W-1:0]          blk_color,
  input  logic signed [XW-1:0]        blk_x,
  input  logic signed [YW-1:0]        blk_y,
  output logic                        resp_valid,
  output logic                        resp_fit,
  output logic [2:0]                  resp_lines,
  output logic                        resp_top_hit,
  input  logic [$clog2(ROWS)-1:0]     rd_row,
  output logic [COLS*COLOR_W-1:0]     rd_data,
  output logic                        field_stable
);

  localparam int RW   = $clog2(ROWS);
  localparam int SW   = ((XW > YW) ? XW : YW) + 1;
  localparam int ROWW = COLS * COLOR_W;

  state_t                state_q, state_d;
  logic [ROWW-1:0]       field_q [ROWS];
  logic [ROWW-1:0]       field_d [ROWS];
  logic [15:0]           mask_q, mask_d;
  logic [COLOR_W-1:0]    color_q, color_d;
  logic signed [XW-1:0]  bx_q, bx_d;
  logic signed [YW-1:0]  by_q, by_d;
  logic [1:0]            chk_q, chk_d;
  logic                  collide_q, collide_d;
  logic                  top_q, top_d;
  logic [2:0]            lines_q, lines_d;
  logic [2:0]            fill_q, fill_d;
  logic [RW-1:0]         rd_q, rd_d;
  logic [RW-1:0]         wr_q, wr_d;

  logic signed [SW-1:0]  bx_s, by_s;
  int                    bx_i, by_i;
  int                    cx, cy;
  logic                  row_full;

  assign bx_s = SW'(bx_q);
  assign by_s = SW'(by_q);
  assign bx_i = int'(bx_s);
  assign by_i = int'(by_s);

  function automatic logic [COLOR_W-1:0] get_cell(input logic [ROWW-1:0] row, input int x);
    logic [COLOR_W-1:0] v;
    v = '0;
    for (int unsigned k = 0; k < COLS; k++) begin
      if (x == int'(k)) v = row[k*COLOR_W +: COLOR_W];
    end
    return v;
  endfunction

  function automatic logic [ROWW-1:0] set_cell(input logic [ROWW-1:0] row, input int x,
                                               input logic [COLOR_W-1:0] c);
    logic [ROWW-1:0] r;
    r = row;
    for (int unsigned k = 0; k < COLS; k++) begin
      if (x == int'(k)) r[k*COLOR_W +: COLOR_W] = c;
    end
    return r;
  endfunction

  // rd_q only ever reaches rows at or above wr_q, so it still sees pre-compaction data.
  tetris_row_full #(.COLS(COLS), .COLOR_W(COLOR_W)) u_row_full (
    .row_i  (field_q[rd_q]),
    .full_o (row_full)
  );

  always_comb begin
    state_d   = state_q;
    field_d   = field_q;
    mask_d    = mask_q;
    color_d   = color_q;
    bx_d      = bx_q;
    by_d      = by_q;
    chk_d     = chk_q;
    collide_d = collide_q;
    top_d     = top_q;
    lines_d   = lines_q;
    fill_d    = fill_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    cx        = 0;
    cy        = 0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          mask_d    = blk_mask;
          color_d   = blk_color;
          bx_d      = blk_x;
          by_d      = blk_y;
          chk_d     = '0;
          collide_d = 1'b0;
          top_d     = 1'b0;
          lines_d   = '0;
          case (cmd_op)
            OP_CLEAR: state_d = ST_CLR;
            OP_MERGE: state_d = ST_MRG;
            default:  state_d = ST_CHK;
          endcase
        end
      end

      ST_CLR: begin
        for (int unsigned r = 0; r < ROWS; r++) field_d[r] = '0;
        state_d = ST_RESP;
      end

      ST_CHK: begin
        for (int unsigned i = 0; i < 4; i++) begin
          for (int unsigned j = 0; j < 4; j++) begin
            if (2'(i) == chk_q && mask_q[4*i+j]) begin
              cx = bx_i + int'(j);
              cy = by_i + int'(i);
              if (cx < 0 || cx >= COLS || cy >= ROWS) collide_d = 1'b1;
              else if (cell_in_field(cx, cy, ROWS, COLS) &&
                       get_cell(field_q[RW'(cy)], cx) != '0) collide_d = 1'b1;
            end
          end
        end
        chk_d = chk_q + 2'd1;
        if (chk_q == 2'd3) state_d = ST_RESP;
      end

      ST_MRG: begin
        for (int unsigned i = 0; i < 4; i++) begin
          for (int unsigned j = 0; j < 4; j++) begin
            if (mask_q[4*i+j]) begin
              cx = bx_i + int'(j);
              cy = by_i + int'(i);
              if (cy < 0) top_d = 1'b1;
              else if (cell_in_field(cx, cy, ROWS, COLS))
                field_d[RW'(cy)] = set_cell(field_d[RW'(cy)], cx, color_q);
            end
          end
        end
        rd_d    = RW'(ROWS - 1);
        wr_d    = RW'(ROWS - 1);
        lines_d = '0;
        state_d = ST_COMPACT;
      end

      ST_COMPACT: begin
        if (row_full) begin
          lines_d = lines_q + 3'd1;
        end else begin
          field_d[wr_q] = field_q[rd_q];
          wr_d          = wr_q - RW'(1);
        end
        rd_d = rd_q - RW'(1);
        if (rd_q == '0) begin
          fill_d  = lines_d;
          state_d = (lines_d == '0) ? ST_RESP : ST_FILL;
        end
      end

      ST_FILL: begin
        field_d[wr_q] = '0;
        wr_d          = wr_q - RW'(1);
        fill_d        = fill_q - 3'd1;
        if (fill_q == 3'd1) state_d = ST_RESP;
      end

      ST_RESP: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      for (int unsigned r = 0; r < ROWS; r++) field_q[r] <= '0;
      mask_q    <= '0;
      color_q   <= '0;
      bx_q      <= '0;
      by_q      <= '0;
      chk_q     <= '0;
      collide_q <= 1'b0;
      top_q     <= 1'b0;
      lines_q   <= '0;
      fill_q    <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
    end else begin
      state_q   <= state_d;
      field_q   <= field_d;
      mask_q    <= mask_d;
      color_q   <= color_d;
      bx_q      <= bx_d;
      by_q      <= by_d;
      chk_q     <= chk_d;
      collide_q <= collide_d;
      top_q     <= top_d;
      lines_q   <= lines_d;
      fill_q    <= fill_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
    end
  end

  assign cmd_ready    = (state_q == ST_IDLE);
  assign resp_valid   = (state_q == ST_RESP);
  assign resp_fit     = resp_valid & ~collide_q;
  assign resp_lines   = resp_valid ? lines_q : '0;
  assign resp_top_hit = resp_valid & top_q;
  assign rd_data      = (int'(rd_row) < ROWS) ? field_q[rd_row] : '0;
  assign field_stable = !(state_q == ST_MRG || state_q == ST_COMPACT || state_q == ST_FILL);

endmodule

// File: tb/tb_tetris_field_engine.sv
// Scoreboard bench for tetris_field_engine: directed commands, queued expected
// responses checked by a negedge monitor, plus direct field readback.
module tb_tetris_field_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [15:0] blk_mask = '0;
  logic [2:0]  blk_color = '0;
  logic signed [5:0] blk_x = '0;
  logic signed [6:0] blk_y = '0;
  logic        resp_valid;
  logic        resp_fit;
  logic [2:0]  resp_lines;
  logic        resp_top_hit;
  logic [4:0]  rd_row = '0;
  logic [29:0] rd_data;
  logic        field_stable;

  typedef struct {
    logic       fit;
    logic [2:0] lines;
    logic       top;
    int         lat;
    int         acc;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [29:0] exp_rows [20];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tetris_field_engine #(.ROWS(20), .COLS(10), .COLOR_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .blk_mask     (blk_mask),
    .blk_color    (blk_color),
    .blk_x        (blk_x),
    .blk_y        (blk_y),
    .resp_valid   (resp_valid),
    .resp_fit     (resp_fit),
    .resp_lines   (resp_lines),
    .resp_top_hit (resp_top_hit),
    .rd_row       (rd_row),
    .rd_data      (rd_data),
    .field_stable (field_stable)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected 0 at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_fit", 64'(resp_fit), 64'(e.fit));
        chk("resp_lines", 64'(resp_lines), 64'(e.lines));
        chk("resp_top_hit", 64'(resp_top_hit), 64'(e.top));
        chk("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
      end
    end
  end

  function automatic logic [29:0] rc(input int c, input logic [2:0] v);
    return 30'(v) << (3 * c);
  endfunction

  task automatic clear_exp();
    for (int r = 0; r < 20; r++) exp_rows[r] = '0;
  endtask

  task automatic check_field(input string tag);
    @(negedge clk);
    for (int r = 0; r < 20; r++) begin
      rd_row = 5'(r);
      #1;
      chk($sformatf("%s_row%0d", tag, r), 64'(rd_data), 64'(exp_rows[r]));
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(cmd_ready && sb.size() == 0) && n < 200);
    if (n >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL resp_timeout: got no response within 200 cycles, expected one");
      sb.delete();
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] m, input logic [2:0] c,
                       input int x, input int y, input bit push, input logic fit,
                       input logic [2:0] ln, input logic top, input int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout: got cmd_ready=0 expected 1");
    end
    cmd_op    = op;
    blk_mask  = m;
    blk_color = c;
    blk_x     = 6'(x);
    blk_y     = 7'(y);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    if (push) sb.push_back('{fit, ln, top, lat, cyc});
    cmd_valid = 1'b0;
    blk_mask  = 16'hFFFF;
    blk_color = 3'd7;
    blk_x     = '0;
    blk_y     = '0;
    if (push) wait_done();
  endtask

  initial begin
    clear_exp();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("reset_resp_valid", 64'(resp_valid), 64'd0);
    chk("reset_field_stable", 64'(field_stable), 64'd1);
    check_field("reset");

    // CHECK on empty field
    issue(2'd1, 16'h0033, 3'd0,  4,  0, 1, 1'b1, 3'd0, 1'b0, 5);
    issue(2'd1, 16'h0033, 3'd0, -1,  0, 1, 1'b0, 3'd0, 1'b0, 5);
    issue(2'd1, 16'h0033, 3'd0,  4, -1, 1, 1'b1, 3'd0, 1'b0, 5);
    issue(2'd3, 16'h0033, 3'd0,  9,  0, 1, 1'b0, 3'd0, 1'b0, 5);
    issue(2'd1, 16'h0033, 3'd0,  0, 19, 1, 1'b0, 3'd0, 1'b0, 5);

    // Build row 19 with a two-column gap at 6..7, then drop an O-piece into it
    issue(2'd2, 16'h000F, 3'd1, 0, 19, 1, 1'b1, 3'd0, 1'b0, 22);
    issue(2'd2, 16'h0003, 3'd2, 4, 19, 1, 1'b1, 3'd0, 1'b0, 22);
    issue(2'd2, 16'h0003, 3'd3, 8, 19, 1, 1'b1, 3'd0, 1'b0, 22);
    exp_rows[19] = rc(0,1) | rc(1,1) | rc(2,1) | rc(3,1) | rc(4,2) | rc(5,2) | rc(8,3) | rc(9,3);
    check_field("row19_built");
    issue(2'd1, 16'h0033, 3'd0, 4, 18, 1, 1'b0, 3'd0, 1'b0, 5);
    issue(2'd1, 16'h0033, 3'd0, 6, 18, 1, 1'b1, 3'd0, 1'b0, 5);
    issue(2'd2, 16'h0033, 3'd5, 6, 18, 1, 1'b1, 3'd1, 1'b0, 23);
    clear_exp();
    exp_rows[19] = rc(6,5) | rc(7,5);
    check_field("one_line");

    issue(2'd0, 16'h0000, 3'd0, 0, 0, 1, 1'b1, 3'd0, 1'b0, 2);
    clear_exp();
    check_field("clear1");

    // Four full rows except column 0, row 17 col 3 = 2, marker at row 15
    issue(2'd2, 16'h0001, 3'd6, 5, 15, 1, 1'b1, 3'd0, 1'b0, 22);
    for (int c = 1; c < 10; c++) begin
      if (c == 3) begin
        issue(2'd2, 16'h1101, 3'd4, 3, 16, 1, 1'b1, 3'd0, 1'b0, 22);
        issue(2'd2, 16'h0001, 3'd2, 3, 17, 1, 1'b1, 3'd0, 1'b0, 22);
      end else begin
        issue(2'd2, 16'h1111, 3'd4, c, 16, 1, 1'b1, 3'd0, 1'b0, 22);
      end
    end
    exp_rows[15] = rc(5,6);
    for (int r = 16; r < 20; r++) begin
      exp_rows[r] = '0;
      for (int c = 1; c < 10; c++) exp_rows[r] = exp_rows[r] | rc(c, (r == 17 && c == 3) ? 3'd2 : 3'd4);
    end
    check_field("four_prefill");
    issue(2'd2, 16'h1111, 3'd1, 0, 16, 1, 1'b1, 3'd4, 1'b0, 26);
    clear_exp();
    exp_rows[19] = rc(5,6);
    check_field("four_lines");

    // Top-out: O-piece half above the field
    issue(2'd0, 16'h0000, 3'd0, 0, 0, 1, 1'b1, 3'd0, 1'b0, 2);
    issue(2'd2, 16'h0033, 3'd7, 2, -1, 1, 1'b1, 3'd0, 1'b1, 22);
    clear_exp();
    exp_rows[0] = rc(2,7) | rc(3,7);
    check_field("top_hit");

    // Reset in the middle of compaction
    issue(2'd2, 16'h000F, 3'd1, 0, 5, 0, 1'b0, 3'd0, 1'b0, 0);
    repeat (5) @(negedge clk);
    chk("compact_unstable", 64'(field_stable), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("abort_resp_valid", 64'(resp_valid), 64'd0);
    clear_exp();
    check_field("abort");
    repeat (30) @(negedge clk);

    // CLEAR on a populated field
    issue(2'd2, 16'h1111, 3'd3, 0, 10, 1, 1'b1, 3'd0, 1'b0, 22);
    issue(2'd2, 16'h000F, 3'd2, 4, 19, 1, 1'b1, 3'd0, 1'b0, 22);
    issue(2'd0, 16'h0000, 3'd0, 0, 0, 1, 1'b1, 3'd0, 1'b0, 2);
    clear_exp();
    check_field("clear2");

    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL pending_resp: got %0d outstanding expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
